// File: rtl/data_select_stage.sv
//==============================================================================
// Module  : data_select_stage
// Brief   : RV32 operand-select stage: regfile read, MEM/WB forwarding,
//           data-hazard and fence.i stall detection. Purely combinational.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module data_select_stage (
    input  logic          clk,
    input  logic          reset,
    input  logic [1023:0] regfile,
    input  logic          ds_valid,
    input  logic [31:0]   ds_pc,
    input  logic [31:0]   ds_inst,
    input  logic [63:0]   ds_inst_id,
    input  logic [4:0]    ds_rs1_addr,
    input  logic [4:0]    ds_rs2_addr,
    input  logic [1:0]    ds_op1_sel,
    input  logic [1:0]    ds_op2_sel,
    input  logic [31:0]   ds_imm,
    input  logic          ds_is_store,
    input  logic          ds_is_branch,
    output logic          ds_exe_valid,
    output logic [31:0]   ds_exe_pc,
    output logic [31:0]   ds_exe_inst,
    output logic [63:0]   ds_exe_inst_id,
    output logic [4:0]    ds_exe_rs1_addr,
    output logic [4:0]    ds_exe_rs2_addr,
    output logic [1:0]    ds_exe_op1_sel,
    output logic [1:0]    ds_exe_op2_sel,
    output logic [31:0]   ds_exe_imm,
    output logic          ds_exe_is_store,
    output logic          ds_exe_is_branch,
    output logic [31:0]   ds_exe_op1_data,
    output logic [31:0]   ds_exe_op2_data,
    output logic [31:0]   ds_exe_rs2_data,
    output logic          dh_stall_flg,
    input  logic          dh_exe_fw_valid,
    input  logic          dh_exe_fw_can_forward,
    input  logic [4:0]    dh_exe_fw_addr,
    input  logic [31:0]   dh_exe_fw_wdata,
    input  logic          dh_mem_fw_valid,
    input  logic          dh_mem_fw_can_forward,
    input  logic [4:0]    dh_mem_fw_addr,
    input  logic [31:0]   dh_mem_fw_wdata,
    input  logic          dh_wb_fw_valid,
    input  logic          dh_wb_fw_can_forward,
    input  logic [4:0]    dh_wb_fw_addr,
    input  logic [31:0]   dh_wb_fw_wdata,
    output logic          zifencei_stall_flg,
    input  logic          zifencei_mem_wen
);

    localparam logic [1:0] c_OP1_X   = 2'd0;
    localparam logic [1:0] c_OP1_RS1 = 2'd1;
    localparam logic [1:0] c_OP1_PC  = 2'd2;
    localparam logic [1:0] c_OP1_IMZ = 2'd3;
    localparam logic [1:0] c_OP2_X   = 2'd0;
    localparam logic [1:0] c_OP2_RS2 = 2'd1;
    localparam logic [1:0] c_OP2_IMM = 2'd2;

    logic [1:0][4:0]  w_rs;
    logic [1:0][31:0] w_val;
    logic [1:0]       w_haz;
    logic             w_rs1_used;
    logic             w_rs2_used;
    logic             w_dh_hazard;
    logic             w_is_fencei;
    logic             w_unused;

    // EXE results are never ready in time; MEM forwards unless it holds a load.
    always_comb begin
        w_rs[0] = ds_rs1_addr;
        w_rs[1] = ds_rs2_addr;
        for (int i = 0; i < 2; i++) begin
            w_val[i] = regfile[{w_rs[i], 5'd0} +: 32];
            w_haz[i] = 1'b0;
            if (w_rs[i] == 5'd0) begin
                w_val[i] = 32'd0;
            end else if (dh_exe_fw_valid && (dh_exe_fw_addr == w_rs[i])) begin
                w_haz[i] = 1'b1;
            end else if (dh_mem_fw_valid && (dh_mem_fw_addr == w_rs[i])) begin
                if (dh_mem_fw_can_forward) begin
                    w_val[i] = dh_mem_fw_wdata;
                end else begin
                    w_haz[i] = 1'b1;
                end
            end else if (dh_wb_fw_valid && (dh_wb_fw_addr == w_rs[i])) begin
                w_val[i] = dh_wb_fw_wdata;
            end
        end
    end

    assign w_rs1_used  = (ds_op1_sel == c_OP1_RS1);
    assign w_rs2_used  = (ds_op2_sel == c_OP2_RS2) || ds_is_store || ds_is_branch;
    assign w_dh_hazard = (w_haz[0] && w_rs1_used) || (w_haz[1] && w_rs2_used);
    assign w_is_fencei = (ds_inst[6:0] == 7'b0001111) && (ds_inst[14:12] == 3'b001);

    assign dh_stall_flg       = ds_valid && !reset && w_dh_hazard;
    assign zifencei_stall_flg = ds_valid && !reset && w_is_fencei && zifencei_mem_wen;
    assign ds_exe_valid       = ds_valid && !reset && !w_dh_hazard
                                && !(w_is_fencei && zifencei_mem_wen);

    always_comb begin
        ds_exe_op1_data = 32'd0;
        case (ds_op1_sel)
            c_OP1_RS1: ds_exe_op1_data = w_val[0];
            c_OP1_PC:  ds_exe_op1_data = ds_pc;
            c_OP1_IMZ: ds_exe_op1_data = {27'd0, ds_inst[19:15]};
            default:   ds_exe_op1_data = 32'd0;
        endcase
    end

    always_comb begin
        ds_exe_op2_data = 32'd0;
        case (ds_op2_sel)
            c_OP2_RS2: ds_exe_op2_data = w_val[1];
            c_OP2_IMM: ds_exe_op2_data = ds_imm;
            c_OP2_X:   ds_exe_op2_data = 32'd0;
            default:   ds_exe_op2_data = 32'd0;
        endcase
    end

    assign ds_exe_rs2_data  = w_val[1];
    assign ds_exe_pc        = ds_pc;
    assign ds_exe_inst      = ds_inst;
    assign ds_exe_inst_id   = ds_inst_id;
    assign ds_exe_rs1_addr  = ds_rs1_addr;
    assign ds_exe_rs2_addr  = ds_rs2_addr;
    assign ds_exe_op1_sel   = ds_op1_sel;
    assign ds_exe_op2_sel   = ds_op2_sel;
    assign ds_exe_imm       = ds_imm;
    assign ds_exe_is_store  = ds_is_store;
    assign ds_exe_is_branch = ds_is_branch;

    // Carried for interface uniformity across stages; not needed here.
    assign w_unused = ^{clk, dh_exe_fw_can_forward, dh_exe_fw_wdata, dh_wb_fw_can_forward};

endmodule

`default_nettype wire

// File: tb/tb_data_select_stage.sv
//==============================================================================
// Module  : tb_data_select_stage
// Brief   : Self-checking bench for data_select_stage (model + directed cases).
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_data_select_stage;

    localparam logic [1:0] c_OP1_X   = 2'd0;
    localparam logic [1:0] c_OP1_RS1 = 2'd1;
    localparam logic [1:0] c_OP1_PC  = 2'd2;
    localparam logic [1:0] c_OP1_IMZ = 2'd3;
    localparam logic [1:0] c_OP2_X   = 2'd0;
    localparam logic [1:0] c_OP2_RS2 = 2'd1;
    localparam logic [1:0] c_OP2_IMM = 2'd2;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   rf [32];
    logic [1023:0] regfile;
    logic          ds_valid;
    logic [31:0]   ds_pc, ds_inst, ds_imm;
    logic [63:0]   ds_inst_id;
    logic [4:0]    ds_rs1_addr, ds_rs2_addr;
    logic [1:0]    ds_op1_sel, ds_op2_sel;
    logic          ds_is_store, ds_is_branch;
    logic          ds_exe_valid, ds_exe_is_store, ds_exe_is_branch;
    logic [31:0]   ds_exe_pc, ds_exe_inst, ds_exe_imm;
    logic [63:0]   ds_exe_inst_id;
    logic [4:0]    ds_exe_rs1_addr, ds_exe_rs2_addr;
    logic [1:0]    ds_exe_op1_sel, ds_exe_op2_sel;
    logic [31:0]   ds_exe_op1_data, ds_exe_op2_data, ds_exe_rs2_data;
    logic          dh_stall_flg, zifencei_stall_flg, zifencei_mem_wen;
    logic          ex_v, ex_cf, mem_v, mem_cf, wb_v, wb_cf;
    logic [4:0]    ex_a, mem_a, wb_a;
    logic [31:0]   ex_d, mem_d, wb_d;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 32; i++) regfile[i*32 +: 32] = rf[i];
    end

    data_select_stage dut (
        .clk(clk), .reset(reset), .regfile(regfile),
        .ds_valid(ds_valid), .ds_pc(ds_pc), .ds_inst(ds_inst), .ds_inst_id(ds_inst_id),
        .ds_rs1_addr(ds_rs1_addr), .ds_rs2_addr(ds_rs2_addr),
        .ds_op1_sel(ds_op1_sel), .ds_op2_sel(ds_op2_sel), .ds_imm(ds_imm),
        .ds_is_store(ds_is_store), .ds_is_branch(ds_is_branch),
        .ds_exe_valid(ds_exe_valid), .ds_exe_pc(ds_exe_pc), .ds_exe_inst(ds_exe_inst),
        .ds_exe_inst_id(ds_exe_inst_id), .ds_exe_rs1_addr(ds_exe_rs1_addr),
        .ds_exe_rs2_addr(ds_exe_rs2_addr), .ds_exe_op1_sel(ds_exe_op1_sel),
        .ds_exe_op2_sel(ds_exe_op2_sel), .ds_exe_imm(ds_exe_imm),
        .ds_exe_is_store(ds_exe_is_store), .ds_exe_is_branch(ds_exe_is_branch),
        .ds_exe_op1_data(ds_exe_op1_data), .ds_exe_op2_data(ds_exe_op2_data),
        .ds_exe_rs2_data(ds_exe_rs2_data), .dh_stall_flg(dh_stall_flg),
        .dh_exe_fw_valid(ex_v), .dh_exe_fw_can_forward(ex_cf),
        .dh_exe_fw_addr(ex_a), .dh_exe_fw_wdata(ex_d),
        .dh_mem_fw_valid(mem_v), .dh_mem_fw_can_forward(mem_cf),
        .dh_mem_fw_addr(mem_a), .dh_mem_fw_wdata(mem_d),
        .dh_wb_fw_valid(wb_v), .dh_wb_fw_can_forward(wb_cf),
        .dh_wb_fw_addr(wb_a), .dh_wb_fw_wdata(wb_d),
        .zifencei_stall_flg(zifencei_stall_flg), .zifencei_mem_wen(zifencei_mem_wen)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Producers listed youngest first; the first one naming rs decides the outcome.
    task automatic model_read(input logic [4:0] rs, output bit haz, output logic [31:0] val);
        bit          pv [3];
        bit          pf [3];
        logic [4:0]  pa [3];
        logic [31:0] pd [3];
        bit          done;
        pv = '{ex_v, mem_v, wb_v};
        pf = '{1'b0, mem_cf, 1'b1};
        pa = '{ex_a, mem_a, wb_a};
        pd = '{ex_d, mem_d, wb_d};
        haz  = 1'b0;
        val  = (rs == 5'd0) ? 32'd0 : rf[rs];
        done = (rs == 5'd0);
        for (int i = 0; i < 3; i++) begin
            if (!done && pv[i] && pa[i] == rs) begin
                done = 1'b1;
                if (pf[i]) val = pd[i];
                else       haz = 1'b1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            bit          h1, h2, use1, use2, stall, fence, zst;
            logic [31:0] v1, v2, e_op1, e_op2;
            model_read(ds_rs1_addr, h1, v1);
            model_read(ds_rs2_addr, h2, v2);
            use1  = (ds_op1_sel == c_OP1_RS1);
            use2  = (ds_op2_sel == c_OP2_RS2) || ds_is_store || ds_is_branch;
            stall = (h1 && use1) || (h2 && use2);
            fence = (ds_inst[6:0] == 7'h0F) && (ds_inst[14:12] == 3'd1);
            zst   = fence && zifencei_mem_wen;
            chk("m_dh_stall", dh_stall_flg, ds_valid && !reset && stall);
            chk("m_zifencei", zifencei_stall_flg, ds_valid && !reset && zst);
            chk("m_exe_valid", ds_exe_valid, ds_valid && !reset && !stall && !zst);
            if (!reset) begin
                e_op1 = (ds_op1_sel == c_OP1_RS1) ? v1 :
                        (ds_op1_sel == c_OP1_PC)  ? ds_pc :
                        (ds_op1_sel == c_OP1_IMZ) ? 32'(ds_inst[19:15]) : 32'd0;
                e_op2 = (ds_op2_sel == c_OP2_RS2) ? v2 :
                        (ds_op2_sel == c_OP2_IMM) ? ds_imm : 32'd0;
                if (!(use1 && h1)) chk("m_op1", ds_exe_op1_data, e_op1);
                if (!(ds_op2_sel == c_OP2_RS2 && h2)) chk("m_op2", ds_exe_op2_data, e_op2);
                if (!h2) chk("m_rs2_data", ds_exe_rs2_data, v2);
                chk("m_pc", ds_exe_pc, ds_pc);
                chk("m_inst", ds_exe_inst, ds_inst);
                chk("m_inst_id", ds_exe_inst_id, ds_inst_id);
                chk("m_ctrl", {ds_exe_rs1_addr, ds_exe_rs2_addr, ds_exe_op1_sel, ds_exe_op2_sel,
                               ds_exe_imm, ds_exe_is_store, ds_exe_is_branch},
                              {ds_rs1_addr, ds_rs2_addr, ds_op1_sel, ds_op2_sel,
                               ds_imm, ds_is_store, ds_is_branch});
            end
        end
    end

    task automatic clear_inputs();
        ds_valid = 1'b1; ds_pc = 32'h0000_1000; ds_inst = 32'h0000_0013;
        ds_inst_id = 64'd1; ds_rs1_addr = 5'd0; ds_rs2_addr = 5'd0;
        ds_op1_sel = c_OP1_RS1; ds_op2_sel = c_OP2_RS2; ds_imm = 32'd0;
        ds_is_store = 1'b0; ds_is_branch = 1'b0; zifencei_mem_wen = 1'b0;
        ex_v = 0; ex_cf = 0; ex_a = 0; ex_d = 0;
        mem_v = 0; mem_cf = 0; mem_a = 0; mem_d = 0;
        wb_v = 0; wb_cf = 1; wb_a = 0; wb_d = 0;
    endtask

    // Inputs change just after posedge; literal checks land just after negedge.
    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + 32'(i) * 32'h111;
        rf[1] = 32'd5;
        rf[2] = 32'd7;
        reset = 1'b1;
        clear_inputs();
        ds_rs1_addr = 5'd1; ex_v = 1; ex_a = 5'd1;
        cmp_en = 1'b1;
        settle();
        chk("reset_stall", dh_stall_flg, 1'b0);
        chk("reset_valid", ds_exe_valid, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;

        // add x3,x1,x2
        clear_inputs();
        ds_inst = 32'h0020_81B3; ds_rs1_addr = 5'd1; ds_rs2_addr = 5'd2;
        settle();
        chk("t1_op1", ds_exe_op1_data, 32'd5);
        chk("t1_op2", ds_exe_op2_data, 32'd7);
        chk("t1_valid", ds_exe_valid, 1'b1);
        chk("t1_stall", dh_stall_flg, 1'b0);

        @(posedge clk); #1;
        clear_inputs();
        ds_rs1_addr = 5'd4;
        mem_v = 1; mem_cf = 1; mem_a = 5'd4; mem_d = 32'hAA;
        wb_v = 1; wb_a = 5'd4; wb_d = 32'hBB;
        settle();
        chk("t2_op1_mem_over_wb", ds_exe_op1_data, 32'hAA);
        chk("t2_stall", dh_stall_flg, 1'b0);

        @(posedge clk); #1;
        mem_v = 0;
        settle();
        chk("t2b_op1_wb", ds_exe_op1_data, 32'hBB);

        @(posedge clk); #1;
        clear_inputs();
        ds_rs1_addr = 5'd4; ex_v = 1; ex_cf = 1; ex_a = 5'd4; ex_d = 32'h55;
        settle();
        chk("t3_exe_stall", dh_stall_flg, 1'b1);
        chk("t3_exe_valid", ds_exe_valid, 1'b0);

        @(posedge clk); #1;
        clear_inputs();
        ds_rs1_addr = 5'd4; mem_v = 1; mem_cf = 0; mem_a = 5'd4;
        settle();
        chk("t3b_load_stall", dh_stall_flg, 1'b1);

        @(posedge clk); #1;
        clear_inputs();
        ds_rs1_addr = 5'd0; ex_v = 1; ex_a = 5'd0;
        settle();
        chk("t4_x0_op1", ds_exe_op1_data, 32'd0);
        chk("t4_x0_stall", dh_stall_flg, 1'b0);

        // lui x5,0x12345: inst[19:15] = 8 but op1 is unused
        @(posedge clk); #1;
        clear_inputs();
        ds_inst = 32'h1234_52B7; ds_rs1_addr = 5'd8; ds_op1_sel = c_OP1_X;
        ds_op2_sel = c_OP2_IMM; ds_imm = 32'h1234_5000; ex_v = 1; ex_a = 5'd8;
        settle();
        chk("t4b_lui_stall", dh_stall_flg, 1'b0);
        chk("t4b_lui_valid", ds_exe_valid, 1'b1);
        chk("t4b_lui_op2", ds_exe_op2_data, 32'h1234_5000);

        @(posedge clk); #1;
        clear_inputs();
        ds_inst = 32'h0000_100F; ds_op1_sel = c_OP1_X; ds_op2_sel = c_OP2_X;
        zifencei_mem_wen = 1;
        settle();
        chk("t5_fencei_stall", zifencei_stall_flg, 1'b1);
        chk("t5_fencei_valid", ds_exe_valid, 1'b0);
        @(posedge clk); #1;
        zifencei_mem_wen = 0;
        settle();
        chk("t5_no_wen", zifencei_stall_flg, 1'b0);
        @(posedge clk); #1;
        zifencei_mem_wen = 1; ds_valid = 0;
        settle();
        chk("t5_not_valid", zifencei_stall_flg, 1'b0);

        @(posedge clk); #1;
        clear_inputs();
        ds_rs1_addr = 5'd9; ex_v = 1; ex_a = 5'd9; reset = 1'b1;
        settle();
        chk("t6_reset_stall", dh_stall_flg, 1'b0);
        chk("t6_reset_valid", ds_exe_valid, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        settle();
        chk("t6_release_stall", dh_stall_flg, 1'b1);

        // Store with imm op2 still needs rs2.
        @(posedge clk); #1;
        clear_inputs();
        ds_rs1_addr = 5'd1; ds_rs2_addr = 5'd6; ds_op2_sel = c_OP2_IMM;
        ds_is_store = 1; ex_v = 1; ex_a = 5'd6;
        settle();
        chk("x_store_stall", dh_stall_flg, 1'b1);

        @(posedge clk); #1;
        clear_inputs();
        ds_op1_sel = c_OP1_PC; ds_pc = 32'h8000_0040; ds_rs2_addr = 5'd2;
        settle();
        chk("x_op1_pc", ds_exe_op1_data, 32'h8000_0040);
        chk("x_rs2_data", ds_exe_rs2_data, 32'd7);

        @(posedge clk); #1;
        clear_inputs();
        ds_op1_sel = c_OP1_IMZ; ds_inst = 32'h000F_8073;
        settle();
        chk("x_op1_imz", ds_exe_op1_data, 32'd31);

        @(posedge clk); #1;
        clear_inputs();
        ds_rs1_addr = 5'd3; ds_rs2_addr = 5'd3; ds_is_branch = 1;
        mem_v = 1; mem_cf = 1; mem_a = 5'd3; mem_d = 32'hDEAD_BEEF;
        settle();
        chk("x_branch_fw_rs2", ds_exe_rs2_data, 32'hDEAD_BEEF);
        chk("x_branch_stall", dh_stall_flg, 1'b0);

        @(posedge clk); #1;
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
